host_mmio_csr_bridge: RTL and testbench

HOST_MMIO_CSR_BRIDGE -- requirements
Module: host_mmio_csr_bridge

---
 rtl/host_mmio_csr_pkg.sv | 45 ++++
 rtl/host_mmio_csr_decode.sv | 23 ++
 rtl/host_mmio_csr_bridge.sv | 215 +++++++++++++++++++++
 tb/tb_host_mmio_csr_bridge.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/host_mmio_csr_pkg.sv
// Shared definitions for the host MMIO CSR bridge: register offsets, select indices,
// FSM states, AXI response codes and the byte-strobe merge helper.
package host_mmio_csr_pkg;

    localparam logic [7:0] REG_REQ_DATA  = 8'h00;
    localparam logic [7:0] REG_REQ_COUNT = 8'h04;
    localparam logic [7:0] REG_RESP_DATA = 8'h08;
    localparam logic [7:0] REG_STATUS    = 8'h0C;
    localparam logic [7:0] REG_SCRATCH   = 8'h10;

    // Bit positions inside the one-hot register select; all-zero means unmapped.
    localparam int NUM_REGS      = 5;
    localparam int SEL_REQ_DATA  = 0;
    localparam int SEL_REQ_COUNT = 1;
    localparam int SEL_RESP_DATA = 2;
    localparam int SEL_STATUS    = 3;
    localparam int SEL_SCRATCH   = 4;

    typedef enum logic [1:0] {
        e_idle    = 2'd0,
        e_rd_resp = 2'd1,
        e_wr_resp = 2'd2
    } state_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    function automatic logic [31:0] apply_wstrb(
        input logic [31:0] old_data,
        input logic [31:0] new_data,
        input logic [3:0]  strb
    );
        logic [31:0] merged;
        merged = old_data;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) begin
                merged[8*b +: 8] = new_data[8*b +: 8];
            end else begin
                merged[8*b +: 8] = old_data[8*b +: 8];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/host_mmio_csr_decode.sv
// Combinational address decode for the host MMIO CSR bridge: low address byte in,
// one-hot register select out (all zeros for an unmapped offset).
import host_mmio_csr_pkg::*;

module host_mmio_csr_decode (
    input  logic [7:0]          i_addr,
    output logic [NUM_REGS-1:0] o_sel
);

    // One-hot select; any offset outside the map leaves every bit clear.
    always_comb begin
        o_sel = '0;
        case (i_addr)
            REG_REQ_DATA:  o_sel[SEL_REQ_DATA]  = 1'b1;
            REG_REQ_COUNT: o_sel[SEL_REQ_COUNT] = 1'b1;
            REG_RESP_DATA: o_sel[SEL_RESP_DATA] = 1'b1;
            REG_STATUS:    o_sel[SEL_STATUS]    = 1'b1;
            REG_SCRATCH:   o_sel[SEL_SCRATCH]   = 1'b1;
            default:       o_sel = '0;
        endcase
    end

endmodule

// File: rtl/host_mmio_csr_bridge.sv
// AXI4-Lite slave exposing the BP MMIO request/response FIFOs as CSRs.
// Optional HOST_MMIO_CSR_ERR_RESP_EN returns SLVERR for empty pops, dropped pushes and unmapped accesses.
import host_mmio_csr_pkg::*;

module host_mmio_csr_bridge #(
    parameter int AXIL_ADDR_WIDTH   = 32,
    parameter int AXIL_DATA_WIDTH   = 32,
    parameter int fifo_data_width_p = 32
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [AXIL_ADDR_WIDTH-1:0]   s_axil_awaddr,
    input  logic                         s_axil_awvalid,
    output logic                         s_axil_awready,
    input  logic [AXIL_DATA_WIDTH-1:0]   s_axil_wdata,
    input  logic [AXIL_DATA_WIDTH/8-1:0] s_axil_wstrb,
    input  logic                         s_axil_wvalid,
    output logic                         s_axil_wready,
    output logic                         s_axil_bvalid,
    input  logic                         s_axil_bready,
    output logic [1:0]                   s_axil_bresp,
    input  logic [AXIL_ADDR_WIDTH-1:0]   s_axil_araddr,
    input  logic                         s_axil_arvalid,
    output logic                         s_axil_arready,
    output logic [AXIL_DATA_WIDTH-1:0]   s_axil_rdata,
    output logic [1:0]                   s_axil_rresp,
    output logic                         s_axil_rvalid,
    input  logic                         s_axil_rready,
    input  logic                         mmio_v_i,
    input  logic [fifo_data_width_p-1:0] mmio_data_i,
    output logic                         mmio_yumi_o,
    input  logic                         mmio_data_count_v_i,
    input  logic [31:0]                  mmio_data_count_i,
    output logic                         mmio_data_count_yumi_o,
    output logic                         mmio_v_o,
    output logic [fifo_data_width_p-1:0] mmio_data_o,
    input  logic                         mmio_ready_and_i
);

`ifdef HOST_MMIO_CSR_ERR_RESP_EN
    localparam logic ERR_EN = 1'b1;
`else
    localparam logic ERR_EN = 1'b0;
`endif

    logic                         r_aw_v;
    logic [7:0]                   r_aw_addr;
    logic                         r_w_v;
    logic [AXIL_DATA_WIDTH-1:0]   r_w_data;
    logic [AXIL_DATA_WIDTH/8-1:0] r_w_strb;
    logic                         r_ar_v;
    logic [7:0]                   r_ar_addr;
    state_e                       r_state;
    logic                         r_last_rd;
    logic [31:0]                  r_scratch;
    logic [15:0]                  r_drop_cnt;
    logic                         r_rvalid;
    logic [AXIL_DATA_WIDTH-1:0]   r_rdata;
    logic [1:0]                   r_rresp;
    logic                         r_bvalid;
    logic [1:0]                   r_bresp;

    logic [NUM_REGS-1:0] w_ar_sel;
    logic [NUM_REGS-1:0] w_aw_sel;
    logic                w_wr_rdy;
    logic                w_rd_rdy;
    logic                w_exec_rd;
    logic                w_exec_wr;
    logic [31:0]         w_rd_data;
    logic                w_rd_err;
    logic                w_wr_err;
    logic                w_unused_addr;

    host_mmio_csr_decode u_ar_decode (
        .i_addr (r_ar_addr),
        .o_sel  (w_ar_sel)
    );

    host_mmio_csr_decode u_aw_decode (
        .i_addr (r_aw_addr),
        .o_sel  (w_aw_sel)
    );

    assign w_unused_addr = ^{s_axil_awaddr[AXIL_ADDR_WIDTH-1:8], s_axil_araddr[AXIL_ADDR_WIDTH-1:8]};

    assign s_axil_awready = ~r_aw_v & ~reset;
    assign s_axil_wready  = ~r_w_v  & ~reset;
    assign s_axil_arready = ~r_ar_v & ~reset;
    assign s_axil_rvalid  = r_rvalid;
    assign s_axil_rdata   = r_rdata;
    assign s_axil_rresp   = r_rresp;
    assign s_axil_bvalid  = r_bvalid;
    assign s_axil_bresp   = r_bresp;

    // On contention the side that did not win last time goes first; reads win after reset.
    assign w_wr_rdy  = r_aw_v & r_w_v;
    assign w_rd_rdy  = r_ar_v;
    assign w_exec_rd = ~reset & (r_state == e_idle) & w_rd_rdy & (~w_wr_rdy | ~r_last_rd);
    assign w_exec_wr = ~reset & (r_state == e_idle) & w_wr_rdy & (~w_rd_rdy | r_last_rd);

    // FIFO handshakes are combinational so the pop/push lands in the execution cycle only.
    assign mmio_yumi_o            = w_exec_rd & w_ar_sel[SEL_REQ_DATA] & mmio_v_i;
    assign mmio_data_count_yumi_o = w_exec_rd & w_ar_sel[SEL_REQ_COUNT] & mmio_data_count_v_i;
    assign mmio_v_o               = w_exec_wr & w_aw_sel[SEL_RESP_DATA] & mmio_ready_and_i;
    assign mmio_data_o            = r_w_data;

    // Read mux and error classification for the held AR address.
    always_comb begin
        w_rd_data = 32'h0000_0000;
        w_rd_err  = 1'b0;
        if (w_ar_sel[SEL_REQ_DATA]) begin
            w_rd_data = mmio_v_i ? mmio_data_i : 32'h0000_0000;
            w_rd_err  = ~mmio_v_i;
        end else if (w_ar_sel[SEL_REQ_COUNT]) begin
            w_rd_data = mmio_data_count_i;
        end else if (w_ar_sel[SEL_STATUS]) begin
            w_rd_data = {r_drop_cnt, 14'd0, mmio_ready_and_i, mmio_v_i};
        end else if (w_ar_sel[SEL_SCRATCH]) begin
            w_rd_data = r_scratch;
        end else if (w_ar_sel[SEL_RESP_DATA]) begin
            w_rd_data = 32'h0000_0000;
        end else begin
            w_rd_err  = 1'b1;
        end
    end

    // Write error: a dropped push or an unmapped offset.
    always_comb begin
        w_wr_err = 1'b0;
        if (w_aw_sel[SEL_RESP_DATA]) begin
            w_wr_err = ~mmio_ready_and_i;
        end else begin
            w_wr_err = (w_aw_sel == '0);
        end
    end

    // Holding registers, transaction FSM, CSR state and registered AXI responses.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_aw_v     <= 1'b0;
            r_aw_addr  <= 8'h00;
            r_w_v      <= 1'b0;
            r_w_data   <= '0;
            r_w_strb   <= '0;
            r_ar_v     <= 1'b0;
            r_ar_addr  <= 8'h00;
            r_state    <= e_idle;
            r_last_rd  <= 1'b0;
            r_scratch  <= 32'h0000_0000;
            r_drop_cnt <= 16'h0000;
            r_rvalid   <= 1'b0;
            r_rdata    <= '0;
            r_rresp    <= RESP_OKAY;
            r_bvalid   <= 1'b0;
            r_bresp    <= RESP_OKAY;
        end else begin
            if (s_axil_awvalid && s_axil_awready) begin
                r_aw_v    <= 1'b1;
                r_aw_addr <= s_axil_awaddr[7:0];
            end
            if (s_axil_wvalid && s_axil_wready) begin
                r_w_v    <= 1'b1;
                r_w_data <= s_axil_wdata;
                r_w_strb <= s_axil_wstrb;
            end
            if (s_axil_arvalid && s_axil_arready) begin
                r_ar_v    <= 1'b1;
                r_ar_addr <= s_axil_araddr[7:0];
            end

            case (r_state)
                e_idle: begin
                    if (w_rd_rdy && w_wr_rdy) begin
                        r_last_rd <= w_exec_rd;
                    end
                    if (w_exec_rd) begin
                        r_ar_v   <= 1'b0;
                        r_rdata  <= w_rd_data;
                        r_rresp  <= (ERR_EN && w_rd_err) ? RESP_SLVERR : RESP_OKAY;
                        r_rvalid <= 1'b1;
                        r_state  <= e_rd_resp;
                    end else if (w_exec_wr) begin
                        r_aw_v <= 1'b0;
                        r_w_v  <= 1'b0;
                        if (w_aw_sel[SEL_SCRATCH]) begin
                            r_scratch <= apply_wstrb(r_scratch, r_w_data, r_w_strb);
                        end
                        if (w_aw_sel[SEL_RESP_DATA] && !mmio_ready_and_i && (r_drop_cnt != 16'hFFFF)) begin
                            r_drop_cnt <= r_drop_cnt + 16'd1;
                        end
                        r_bresp  <= (ERR_EN && w_wr_err) ? RESP_SLVERR : RESP_OKAY;
                        r_bvalid <= 1'b1;
                        r_state  <= e_wr_resp;
                    end
                end
                e_rd_resp: begin
                    if (s_axil_rready) begin
                        r_rvalid <= 1'b0;
                        r_state  <= e_idle;
                    end
                end
                e_wr_resp: begin
                    if (s_axil_bready) begin
                        r_bvalid <= 1'b0;
                        r_state  <= e_idle;
                    end
                end
                default: begin
                    r_state <= e_idle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_host_mmio_csr_bridge.sv
// Scoreboard bench for host_mmio_csr_bridge: stimulus pushes model expectations, a monitor
// pops and compares read data, write responses and FIFO pushes as the DUT presents them.
`timescale 1ns/1ps
module tb_host_mmio_csr_bridge;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;
`ifdef HOST_MMIO_CSR_ERR_RESP_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] awaddr = '0, araddr = '0, wdata = '0;
    logic [3:0]  wstrb = '0;
    logic        awvalid = 1'b0, wvalid = 1'b0, arvalid = 1'b0;
    logic        awready, wready, arready;
    logic        bvalid, rvalid;
    logic        bready = 1'b0, rready = 1'b0;
    logic [1:0]  bresp, rresp;
    logic [31:0] rdata;
    logic        mmio_v_i = 1'b0, count_v = 1'b0, ready_and = 1'b0;
    logic [31:0] mmio_data_i = '0, count_i = '0;
    logic        yumi, count_yumi, mmio_v_o;
    logic [31:0] mmio_data_o;

    always #5 clk = ~clk;

    host_mmio_csr_bridge dut (
        .clk(clk), .reset(reset),
        .s_axil_awaddr(awaddr), .s_axil_awvalid(awvalid), .s_axil_awready(awready),
        .s_axil_wdata(wdata), .s_axil_wstrb(wstrb), .s_axil_wvalid(wvalid), .s_axil_wready(wready),
        .s_axil_bvalid(bvalid), .s_axil_bready(bready), .s_axil_bresp(bresp),
        .s_axil_araddr(araddr), .s_axil_arvalid(arvalid), .s_axil_arready(arready),
        .s_axil_rdata(rdata), .s_axil_rresp(rresp), .s_axil_rvalid(rvalid), .s_axil_rready(rready),
        .mmio_v_i(mmio_v_i), .mmio_data_i(mmio_data_i), .mmio_yumi_o(yumi),
        .mmio_data_count_v_i(count_v), .mmio_data_count_i(count_i), .mmio_data_count_yumi_o(count_yumi),
        .mmio_v_o(mmio_v_o), .mmio_data_o(mmio_data_o), .mmio_ready_and_i(ready_and)
    );

    typedef struct packed { logic [31:0] data; logic [1:0] resp; } rexp_t;

    int          n_cmp = 0, n_err = 0;
    int          n_rdone = 0, n_bdone = 0, n_yumi = 0, n_cyumi = 0;
    rexp_t       q_r[$];
    logic [1:0]  q_b[$];
    logic [31:0] q_push[$];
    logic [31:0] m_scratch = '0;
    logic [15:0] m_drop = '0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Reference model: register map semantics evaluated against the current bench inputs.
    function automatic rexp_t exp_read(input logic [31:0] a);
        rexp_t e;
        logic [7:0] off;
        off = a[7:0];
        e.data = 32'h0;
        e.resp = OKAY;
        case (off)
            8'h00: begin
                e.data = mmio_v_i ? mmio_data_i : 32'h0;
                if (!mmio_v_i && ERR_EN) e.resp = SLVERR;
            end
            8'h04: e.data = count_i;
            8'h08: e.data = 32'h0;
            8'h0C: e.data = {m_drop, 14'd0, ready_and, mmio_v_i};
            8'h10: e.data = m_scratch;
            default: if (ERR_EN) e.resp = SLVERR;
        endcase
        return e;
    endfunction

    task automatic model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        logic [1:0] r;
        logic [7:0] off;
        off = a[7:0];
        r = OKAY;
        case (off)
            8'h08: begin
                if (ready_and) q_push.push_back(d);
                else begin
                    if (m_drop != 16'hFFFF) m_drop = m_drop + 16'd1;
                    if (ERR_EN) r = SLVERR;
                end
            end
            8'h10: for (int b = 0; b < 4; b++) if (s[b]) m_scratch[8*b +: 8] = d[8*b +: 8];
            8'h00, 8'h04, 8'h0C: r = OKAY;
            default: if (ERR_EN) r = SLVERR;
        endcase
        q_b.push_back(r);
    endtask

    // Monitor: compare every presented response / push against the scoreboard queues.
    always @(negedge clk) begin
        if (rvalid === 1'b1 && rready) begin
            if (q_r.size() == 0) begin
                n_cmp++; n_err++;
                $display("FAIL unexpected_rresp: got rdata %h, expected no response", rdata);
            end else begin
                rexp_t e;
                e = q_r.pop_front();
                check("rdata", rdata, e.data);
                check("rresp", {30'd0, rresp}, {30'd0, e.resp});
            end
            n_rdone++;
        end
        if (bvalid === 1'b1 && bready) begin
            if (q_b.size() == 0) begin
                n_cmp++; n_err++;
                $display("FAIL unexpected_bresp: got %b, expected no response", bresp);
            end else begin
                logic [1:0] eb;
                eb = q_b.pop_front();
                check("bresp", {30'd0, bresp}, {30'd0, eb});
            end
            n_bdone++;
        end
        if (mmio_v_o === 1'b1) begin
            if (q_push.size() == 0) begin
                n_cmp++; n_err++;
                $display("FAIL unexpected_push: got data %h, expected no push", mmio_data_o);
            end else begin
                logic [31:0] ep;
                ep = q_push.pop_front();
                check("push_data", mmio_data_o, ep);
            end
        end
        if (yumi === 1'b1) n_yumi++;
        if (count_yumi === 1'b1) n_cyumi++;
    end

    // Raise the requested channels together and drop each once its handshake is seen.
    task automatic issue(input bit do_rd, input logic [31:0] ra, input bit do_wr,
                         input logic [31:0] wa, input logic [31:0] wd, input logic [3:0] ws);
        bit ar_p, aw_p, w_p, hs_ar, hs_aw, hs_w;
        int t;
        t = 0;
        @(posedge clk); #1;
        arvalid = do_rd; araddr = ra;
        awvalid = do_wr; awaddr = wa; wvalid = do_wr; wdata = wd; wstrb = ws;
        ar_p = do_rd; aw_p = do_wr; w_p = do_wr;
        while (ar_p || aw_p || w_p) begin
            @(negedge clk);
            hs_ar = arvalid & arready; hs_aw = awvalid & awready; hs_w = wvalid & wready;
            @(posedge clk); #1;
            if (hs_ar) begin ar_p = 0; arvalid = 1'b0; end
            if (hs_aw) begin aw_p = 0; awvalid = 1'b0; end
            if (hs_w)  begin w_p = 0;  wvalid = 1'b0; end
            t++;
            if (t > 50) begin
                n_cmp++; n_err++;
                $display("FAIL handshake_timeout: got no ready after %0d cycles, expected ready", t);
                arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
                break;
            end
        end
    endtask

    task automatic wait_resp(input int nr, input int nb);
        int t;
        t = 0;
        while ((n_rdone < nr || n_bdone < nb) && t < 200) begin
            @(posedge clk); #1;
            rready = 1'($urandom_range(0, 1));
            bready = 1'($urandom_range(0, 1));
            t++;
        end
        if (t >= 200) begin
            n_cmp++; n_err++;
            $display("FAIL response_timeout: got %0d/%0d responses, expected %0d/%0d", n_rdone, n_bdone, nr, nb);
        end
        @(posedge clk); #1;
        rready = 1'b0; bready = 1'b0;
    endtask

    task automatic do_read(input logic [31:0] a);
        int nr, ey, ecy;
        nr  = n_rdone + 1;
        ey  = n_yumi + ((a[7:0] == 8'h00 && mmio_v_i) ? 1 : 0);
        ecy = n_cyumi + ((a[7:0] == 8'h04 && count_v) ? 1 : 0);
        q_r.push_back(exp_read(a));
        issue(1'b1, a, 1'b0, 32'h0, 32'h0, 4'h0);
        wait_resp(nr, n_bdone);
        check("yumi_count", n_yumi, ey);
        check("count_yumi_count", n_cyumi, ecy);
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        int nb;
        nb = n_bdone + 1;
        model_write(a, d, s);
        issue(1'b0, 32'h0, 1'b1, a, d, s);
        wait_resp(n_rdone, nb);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b1; arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0; rready = 1'b0; bready = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        m_scratch = 32'h0; m_drop = 16'h0;
    endtask

    logic [7:0] addr_tab [8] = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h14, 8'hFC, 8'h02};

    initial begin
        rexp_t e;
        int nr, nb, ey, t;
        logic [31:0] a;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_outputs", {20'd0, awready, wready, arready, rvalid, bvalid, mmio_v_o, yumi,
                                count_yumi, rresp, bresp}, 32'h0);
        check("reset_rdata", rdata, 32'h0);
        @(posedge clk); #1 reset = 1'b0;

        // Empty pop, then a real pop with latency check.
        mmio_v_i = 1'b0;
        do_read(32'h0);
        mmio_v_i = 1'b1; mmio_data_i = 32'h8000_1000;
        ey = n_yumi + 1; nr = n_rdone + 1;
        q_r.push_back(exp_read(32'h0));
        issue(1'b1, 32'h0, 1'b0, 32'h0, 32'h0, 4'h0);
        @(negedge clk); check("rvalid_1cyc_after_hs", {31'd0, rvalid}, 32'd0);
        @(negedge clk); check("rvalid_2cyc_after_hs", {31'd0, rvalid}, 32'd1);
        wait_resp(nr, n_bdone);
        check("pop_yumi_once", n_yumi, ey);

        // Push accepted, push dropped, drop count visible in STATUS.
        ready_and = 1'b1; do_write(32'h08, 32'h0000_00AB, 4'hF);
        ready_and = 1'b0; do_write(32'h08, 32'h0000_00CD, 4'hF);
        do_read(32'h0C);

        // Contention: read wins first, write wins the next one.
        ready_and = 1'b1;
        do_write(32'h10, 32'hAAAA_0001, 4'hF);
        nr = n_rdone + 1; nb = n_bdone + 1;
        q_r.push_back(exp_read(32'h10));
        model_write(32'h10, 32'h5555_0002, 4'hF);
        issue(1'b1, 32'h10, 1'b1, 32'h10, 32'h5555_0002, 4'hF);
        wait_resp(nr, nb);
        nr = n_rdone + 1; nb = n_bdone + 1;
        model_write(32'h10, 32'h3333_0003, 4'hF);
        q_r.push_back(exp_read(32'h10));
        issue(1'b1, 32'h10, 1'b1, 32'h10, 32'h3333_0003, 4'hF);
        wait_resp(nr, nb);

        // Backpressure: rvalid/rdata held, second AR captured once then arready low.
        count_v = 1'b1; count_i = 32'h0000_0042;
        nr = n_rdone + 2;
        e = exp_read(32'h10);
        q_r.push_back(e);
        issue(1'b1, 32'h10, 1'b0, 32'h0, 32'h0, 4'h0);
        @(negedge clk); @(negedge clk);
        check("bp_rvalid_rise", {31'd0, rvalid}, 32'd1);
        q_r.push_back(exp_read(32'h04));
        ey = n_cyumi + 1;
        @(posedge clk); #1 arvalid = 1'b1; araddr = 32'h04;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check("bp_rvalid_held", {31'd0, rvalid}, 32'd1);
            check("bp_rdata_held", rdata, e.data);
            check("bp_arready", {31'd0, arready}, (k == 0) ? 32'd1 : 32'd0);
            @(posedge clk); #1;
            if (k == 0) arvalid = 1'b0;
        end
        wait_resp(nr, n_bdone);
        check("bp_count_yumi", n_cyumi, ey);
        count_v = 1'b0;

        // SCRATCH byte strobes, then reset clears it.
        do_write(32'h10, 32'h1234_5678, 4'hF);
        do_write(32'h10, 32'hFFFF_FFFF, 4'b0001);
        do_read(32'h10);
        do_reset();
        do_read(32'h10);
        do_read(32'h0C);

        // Reset between capture and execution abandons the push.
        ready_and = 1'b1;
        nb = n_bdone;
        issue(1'b0, 32'h0, 1'b1, 32'h08, 32'h0000_DEAD, 4'hF);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        m_scratch = 32'h0; m_drop = 16'h0;
        repeat (5) @(posedge clk);
        check("abandoned_no_bresp", n_bdone, nb);

        // Randomized single transactions against the model.
        for (int i = 0; i < 60; i++) begin
            mmio_v_i = 1'($urandom_range(0, 1)); mmio_data_i = $urandom;
            count_v = 1'($urandom_range(0, 1));  count_i = $urandom;
            ready_and = 1'($urandom_range(0, 1));
            a = $urandom;
            a[7:0] = addr_tab[$urandom_range(0, 7)];
            if ($urandom_range(0, 1) == 0) do_read(a);
            else do_write(a, $urandom, 4'($urandom_range(0, 15)));
        end

        t = 0;
        check("queues_drained", q_r.size() + q_b.size() + q_push.size(), t);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
